vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_if.sv | 42 ++++
 rtl/vga_timing.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if -- timing bundle produced by vga_timing and consumed by draw_bg.
//
// Signals
//   hcount[10:0]  pixel index within the current line
//   vcount[10:0]  line index within the current frame
//   hsync         horizontal sync pulse, active-high
//   vsync         vertical sync pulse, active-high
//   hblnk         1 while hcount is outside the visible region
//   vblnk         1 while vcount is outside the visible region
//   rgb[11:0]     pixel colour (black from the timing generator)
//
// Modports
//   out / master  driver side (vga_timing)
//   in  / slave   receiver side (draw_bg)
// ---------------------------------------------------------------------------
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport out (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport in (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    // Generic names for the same two directions.
    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );
endinterface : vga_if

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing -- free-running VGA raster timing generator.
//
// Produces horizontal/vertical pixel counters plus sync and blanking flags
// for a display whose geometry is set by the H_* / V_* parameters. The
// default geometry is 800x600 (1056 x 628 total). Every output is a flop;
// flags are decoded from the counters' next values so that a flag always
// changes on the same edge as the counter value it describes.
//
// Ports
//   clk          in   pixel clock, rising-edge active
//   rst          in   asynchronous, active-high reset
//   out          vga_if.out  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
//   frame_start  out  one-cycle strobe coincident with (0,0) reached by
//                     wrap-around; only present when the macro
//                     VGA_TIMING_FRAME_PULSE_EN is defined
//
// Optional feature
//   VGA_TIMING_FRAME_PULSE_EN  adds the frame_start port and its flop.
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic clk,
    input  logic rst,
    vga_if.out   out
`ifdef VGA_TIMING_FRAME_PULSE_EN
    ,
    output logic frame_start
`endif
);

    // -----------------------------------------------------------------------
    // Geometry
    // -----------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CNT_MAX = 2047;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // The counters are 11 bits; any geometry that does not fit is rejected
    // while the design is being elaborated rather than silently wrapping.
    if (H_TOTAL > CNT_MAX) begin : g_h_total_chk
        $error("vga_timing: horizontal total %0d exceeds %0d", H_TOTAL, CNT_MAX);
    end
    if (V_TOTAL > CNT_MAX) begin : g_v_total_chk
        $error("vga_timing: vertical total %0d exceeds %0d", V_TOTAL, CNT_MAX);
    end
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_active_chk
        $error("vga_timing: active region must be at least one pixel/line");
    end

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        hsync_q;
    logic        vsync_q;
    logic        hblnk_q;
    logic        vblnk_q;

    // Next-state counter values and wrap conditions.
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;
    logic        v_wrap;

    // NOTE: every signal assigned in always_comb gets a value before any
    // conditional assignment, so no path leaves it holding state (no latch).
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        v_wrap = (v_cnt == V_LAST);
        h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt  = v_cnt;
        // The line counter only moves on the edge where the pixel counter
        // wraps; both return to zero together at the end of a frame.
        if (h_wrap) begin
            v_nxt = v_wrap ? 11'd0 : v_cnt + 11'd1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            hsync_q <= 1'b0;
            vsync_q <= 1'b0;
            hblnk_q <= 1'b0;
            vblnk_q <= 1'b0;
        end else begin
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            // Flags decode the values the counters are about to take, so
            // the registered flag lines up with the registered count.
            hblnk_q <= (h_nxt >= H_VIS_END);
            vblnk_q <= (v_nxt >= V_VIS_END);
            hsync_q <= (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END);
            vsync_q <= (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END);
        end
    end

`ifdef VGA_TIMING_FRAME_PULSE_EN
    // Set only when both counters wrap on this edge. The post-reset (0,0)
    // state is not a wrap, so the strobe stays low there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= h_wrap && v_wrap;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out.hcount = h_cnt;
    assign out.vcount = v_cnt;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    // The timing generator never draws; the background stage fills colour.
    assign out.rgb    = 12'h000;

endmodule : vga_timing
